// File: rtl/config_selector_pkg.sv
// Shared definitions for the config_selector block: FSM encoding, default
// mode-word width and the default slot word constants used to build the
// slot_table at the integration level.
package config_selector_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_QUALIFY = 2'd1,
    ST_COMMIT  = 2'd2
  } state_e;

  localparam int DEFAULT_MODE_SIZE = 8;

  localparam logic [DEFAULT_MODE_SIZE-1:0] SLOT0_WORD = 8'h11;
  localparam logic [DEFAULT_MODE_SIZE-1:0] SLOT1_WORD = 8'h22;
  localparam logic [DEFAULT_MODE_SIZE-1:0] SLOT2_WORD = 8'h33;
  localparam logic [DEFAULT_MODE_SIZE-1:0] SLOT3_WORD = 8'h44;
  localparam logic [DEFAULT_MODE_SIZE-1:0] SLOT4_WORD = 8'h55;

  // Five-slot table in flattened form: slot k at [k*8 +: 8].
  localparam logic [5*DEFAULT_MODE_SIZE-1:0] DEFAULT_SLOT_TABLE =
    {SLOT4_WORD, SLOT3_WORD, SLOT2_WORD, SLOT1_WORD, SLOT0_WORD};

endpackage

// File: rtl/config_selector_sync_debounce.sv
// Two-flop synchroniser for the switch bank plus the saturating stable-cycle
// counter used to qualify a candidate slot. The counter is steered by the
// owning FSM (clear / increment); done_o flags that the increment happening
// on this edge brings the count to DEBOUNCE_CYCLES-1.
module config_selector_sync_debounce #(
  parameter int WIDTH           = 5,
  parameter int DEBOUNCE_CYCLES = 1024
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] async_i,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [WIDTH-1:0] sync_o,
  output logic             done_o
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;
  logic [CNT_W-1:0] cnt_q;

  // Two-stage synchroniser for the asynchronous switch inputs.
  always_ff @(posedge clock) begin
    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge value of its source, regardless of statement order.
    if (!reset_n) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= async_i;
      sync_q <= meta_q;
    end
  end

  // Stable-cycle counter; saturates at DEBOUNCE_CYCLES instead of wrapping.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (inc_i && (cnt_q != CNT_MAX)) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign sync_o = sync_q;
  assign done_o = (int'(cnt_q) + 1) >= (DEBOUNCE_CYCLES - 1);

endmodule

// File: rtl/config_selector.sv
// config_selector: synchronises and debounces an N-bit switch bank, decodes a
// one-hot or one-cold pattern into a slot index and commits that slot's mode
// word, pulsing config_changed on each commit that changes the index.
// Optional feature macro: CONFIG_SELECTOR_OVERRIDE_EN adds override_valid /
// override_slot for a direct, debounce-free commit.
module config_selector
  import config_selector_pkg::*;
#(
  parameter int NUM_SLOTS       = 5,
  parameter int MODE_SIZE       = DEFAULT_MODE_SIZE,
  parameter int DEBOUNCE_CYCLES = 1024,
  parameter int DEFAULT_SLOT    = 0
) (
  input  logic                           clock,
  input  logic                           reset_n,
  input  logic [NUM_SLOTS-1:0]           config_in,
  input  logic [NUM_SLOTS*MODE_SIZE-1:0] slot_table,
  output logic [MODE_SIZE-1:0]           config_data,
  output logic [$clog2(NUM_SLOTS)-1:0]   slot_index,
  output logic                           config_changed,
  output logic                           config_invalid
`ifdef CONFIG_SELECTOR_OVERRIDE_EN
  ,
  input  logic                           override_valid,
  input  logic [$clog2(NUM_SLOTS)-1:0]   override_slot
`endif
);

  localparam int IDX_W = $clog2(NUM_SLOTS);
  localparam int POP_W = $clog2(NUM_SLOTS + 1);

  logic [NUM_SLOTS-1:0] sync_in;
  logic                 cnt_clr;
  logic                 cnt_inc;
  logic                 cnt_done;

  logic [MODE_SIZE-1:0] slot_words [NUM_SLOTS];

  logic [POP_W-1:0]     hot_cnt;
  logic [POP_W-1:0]     cold_cnt;
  logic [IDX_W-1:0]     hot_pos;
  logic [IDX_W-1:0]     cold_pos;
  logic                 cand_valid;
  logic [IDX_W-1:0]     cand;

  state_e               state_q, state_d;
  logic [IDX_W-1:0]     pending_q, pending_d;
  logic [IDX_W-1:0]     index_q, index_d;
  logic [MODE_SIZE-1:0] data_q, data_d;
  logic                 changed_q, changed_d;
  logic                 invalid_q;

  logic                 commit_en;
  logic [IDX_W-1:0]     commit_slot;

  config_selector_sync_debounce #(
    .WIDTH          (NUM_SLOTS),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_sync_debounce (
    .clock  (clock),
    .reset_n(reset_n),
    .async_i(config_in),
    .clr_i  (cnt_clr),
    .inc_i  (cnt_inc),
    .sync_o (sync_in),
    .done_o (cnt_done)
  );

  // Unflatten the mode table so slots can be selected by index.
  always_comb begin
    for (int k = 0; k < NUM_SLOTS; k++) begin
      slot_words[k] = slot_table[k*MODE_SIZE +: MODE_SIZE];
    end
  end

  // Classify the synchronised bank: one-hot wins over one-cold, else invalid.
  always_comb begin
    // NOTE: every variable gets a default before any conditional assignment,
    // so no path can leave a value held and infer a latch.
    hot_cnt  = '0;
    cold_cnt = '0;
    hot_pos  = '0;
    cold_pos = '0;
    for (int k = 0; k < NUM_SLOTS; k++) begin
      if (sync_in[k]) begin
        hot_cnt = hot_cnt + POP_W'(1);
        hot_pos = IDX_W'(k);
      end else begin
        cold_cnt = cold_cnt + POP_W'(1);
        cold_pos = IDX_W'(k);
      end
    end
    cand_valid = (hot_cnt == POP_W'(1)) || (cold_cnt == POP_W'(1));
    cand       = (hot_cnt == POP_W'(1)) ? hot_pos : cold_pos;
  end

  // Next-state logic: qualify a new candidate, then commit it for one cycle.
  always_comb begin
    state_d     = state_q;
    pending_d   = pending_q;
    cnt_clr     = 1'b0;
    cnt_inc     = 1'b0;
    commit_en   = 1'b0;
    commit_slot = pending_q;

    case (state_q)
      ST_IDLE: begin
        if (cand_valid && (cand != index_q)) begin
          pending_d = cand;
          cnt_clr   = 1'b1;
          state_d   = ST_QUALIFY;
        end
      end
      ST_QUALIFY: begin
        if (!cand_valid) begin
          state_d = ST_IDLE;
        end else if (cand != pending_q) begin
          // A bounce to another valid slot restarts qualification.
          pending_d = cand;
          cnt_clr   = 1'b1;
        end else begin
          cnt_inc = 1'b1;
          // The counter lands on DEBOUNCE_CYCLES-1 on the same edge that
          // enters COMMIT.
          if (cnt_done) state_d = ST_COMMIT;
        end
      end
      ST_COMMIT: begin
        commit_en = 1'b1;
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

`ifdef CONFIG_SELECTOR_OVERRIDE_EN
    // An in-range override commits immediately and abandons any qualification.
    if (override_valid && (int'(override_slot) < NUM_SLOTS)) begin
      commit_en   = 1'b1;
      commit_slot = override_slot;
      pending_d   = override_slot;
      cnt_clr     = 1'b1;
      cnt_inc     = 1'b0;
      state_d     = ST_IDLE;
    end
`endif

    index_d   = commit_en ? commit_slot : index_q;
    data_d    = commit_en ? slot_words[commit_slot] : data_q;
    changed_d = commit_en && (commit_slot != index_q);
  end

  // State and output registers; the default word is reloaded throughout reset.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      pending_q <= '0;
      index_q   <= IDX_W'(DEFAULT_SLOT);
      data_q    <= slot_words[DEFAULT_SLOT];
      changed_q <= 1'b0;
      invalid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      index_q   <= index_d;
      data_q    <= data_d;
      changed_q <= changed_d;
      invalid_q <= !cand_valid;
    end
  end

  assign config_data    = data_q;
  assign slot_index     = index_q;
  assign config_changed = changed_q;
  assign config_invalid = invalid_q;

endmodule

// File: tb/tb_config_selector.sv
// Scoreboard bench for config_selector (5 slots, 8-bit words, 4-cycle
// debounce). Stimulus pushes the expected commit (index, word, edge number)
// and a negedge monitor pops one entry per config_changed pulse.
`timescale 1ns/1ps
module tb_config_selector;
  import config_selector_pkg::*;

  localparam int NS = 5;
  localparam int MS = 8;
  localparam int DC = 4;

  logic          clock = 1'b0;
  logic          reset_n;
  logic [NS-1:0] config_in;
  logic [NS*MS-1:0] slot_table;
  logic [MS-1:0] config_data;
  logic [2:0]    slot_index;
  logic          config_changed;
  logic          config_invalid;
`ifdef CONFIG_SELECTOR_OVERRIDE_EN
  logic          override_valid;
  logic [2:0]    override_slot;
`endif

  typedef struct {
    logic [2:0] idx;
    logic [7:0] data;
    int         cyc;
  } exp_t;

  exp_t exp_q[$];
  int   tests_run    = 0;
  int   tests_failed = 0;
  int   cyc          = 0;

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  config_selector #(
    .NUM_SLOTS      (NS),
    .MODE_SIZE      (MS),
    .DEBOUNCE_CYCLES(DC),
    .DEFAULT_SLOT   (0)
  ) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .config_in     (config_in),
    .slot_table    (slot_table),
    .config_data   (config_data),
    .slot_index    (slot_index),
    .config_changed(config_changed),
    .config_invalid(config_invalid)
`ifdef CONFIG_SELECTOR_OVERRIDE_EN
    ,
    .override_valid(override_valid),
    .override_slot (override_slot)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Drive a switch pattern (called just after a negedge) and expect its commit
  // at edge N+2+DC, where N is the next rising edge.
  task automatic apply(input logic [NS-1:0] pat, input logic [2:0] idx, input logic [7:0] data);
    exp_t e;
    config_in = pat;
    e.idx  = idx;
    e.data = data;
    e.cyc  = cyc + 1 + 2 + DC;
    exp_q.push_back(e);
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clock);
  endtask

  // Monitor: every config_changed pulse must match the oldest expectation.
  always @(negedge clock) begin
    exp_t e;
    if (config_changed === 1'b1) begin
      check("pulse_has_expectation", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("commit_index", 32'(slot_index), 32'(e.idx));
        check("commit_data", 32'(config_data), 32'(e.data));
        check("commit_edge", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  initial begin
    reset_n    = 1'b0;
    config_in  = 5'b00001;
    slot_table = DEFAULT_SLOT_TABLE;
`ifdef CONFIG_SELECTOR_OVERRIDE_EN
    override_valid = 1'b0;
    override_slot  = 3'd0;
`endif
    wait_cycles(3);
    check("reset_data", 32'(config_data), 32'h11);
    check("reset_index", 32'(slot_index), 32'd0);
    check("reset_changed", 32'(config_changed), 32'd0);
    check("reset_invalid", 32'(config_invalid), 32'd0);

    // Release with the default slot already selected: no commit expected.
    reset_n = 1'b1;
    wait_cycles(10);
    check("release_data", 32'(config_data), 32'h11);
    check("release_index", 32'(slot_index), 32'd0);
    check("release_invalid", 32'(config_invalid), 32'd0);

    // One-hot move to slot 2.
    apply(5'b00100, 3'd2, 8'h33);
    wait_cycles(12);
    check("onehot_data", 32'(config_data), 32'h33);
    check("onehot_index", 32'(slot_index), 32'd2);

    // One-cold pattern selecting slot 1.
    apply(5'b11101, 3'd1, 8'h22);
    wait_cycles(12);
    check("onecold_data", 32'(config_data), 32'h22);
    check("onecold_index", 32'(slot_index), 32'd1);

    // Back to slot 0 so the bounce scenario ends on a real change to slot 1.
    apply(5'b00001, 3'd0, 8'h11);
    wait_cycles(12);
    check("back_to_0_data", 32'(config_data), 32'h11);

    // Slot 3 seen for only 3 cycles, then slot 1 held: slot 3 never commits.
    config_in = 5'b01000;
    wait_cycles(3);
    apply(5'b00010, 3'd1, 8'h22);
    wait_cycles(12);
    check("bounce_data", 32'(config_data), 32'h22);
    check("bounce_index", 32'(slot_index), 32'd1);

    // Two bits set: invalid, configuration held.
    config_in = 5'b00110;
    wait_cycles(4);
    check("invalid_flag", 32'(config_invalid), 32'd1);
    check("invalid_data_held", 32'(config_data), 32'h22);

    // Table edits outside commit/reset do not reach config_data.
    slot_table[15:8] = 8'h99;
    wait_cycles(3);
    check("table_edit_ignored", 32'(config_data), 32'h22);
    slot_table = DEFAULT_SLOT_TABLE;

    // Start qualifying slot 2, then reset mid-QUALIFY: abort, no pulse.
    config_in = 5'b00100;
    wait_cycles(4);
    check("pre_reset_invalid_clear", 32'(config_invalid), 32'd0);
    reset_n   = 1'b0;
    config_in = 5'b00001;
    wait_cycles(1);
    check("abort_data", 32'(config_data), 32'h11);
    check("abort_index", 32'(slot_index), 32'd0);
    check("abort_changed", 32'(config_changed), 32'd0);
    wait_cycles(1);
    reset_n = 1'b1;
    wait_cycles(10);
    check("post_abort_data", 32'(config_data), 32'h11);

`ifdef CONFIG_SELECTOR_OVERRIDE_EN
    // Park the switches on an invalid pattern so only overrides act.
    config_in = 5'b00000;
    wait_cycles(5);
    begin
      exp_t e;
      override_valid = 1'b1;
      override_slot  = 3'd4;
      e.idx  = 3'd4;
      e.data = 8'h55;
      e.cyc  = cyc + 1;
      exp_q.push_back(e);
    end
    wait_cycles(1);
    override_valid = 1'b0;
    wait_cycles(3);
    check("override_data", 32'(config_data), 32'h55);
    check("override_index", 32'(slot_index), 32'd4);
    override_valid = 1'b1;
    override_slot  = 3'd7;
    wait_cycles(1);
    override_valid = 1'b0;
    wait_cycles(3);
    check("override_oor_data", 32'(config_data), 32'h55);
    check("override_oor_index", 32'(slot_index), 32'd4);
`endif

    wait_cycles(5);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
